seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have one parameter: SCAN_DIV, default 4, number of clock cycles each digit slot lasts; legal range 2..65535.
REQ-002 The block SHALL have the port iClk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port iRst  input  1  reset; synchronous, active-high.
REQ-004 The block SHALL have the port iEn  input  1  scan enable; low freezes the scan and blanks the display.
REQ-005 The block SHALL have the ports iD1, iD2, iD3, iD4  input  4 each  hex digits from the counter chain; iD1 is least significant.
REQ-006 The block SHALL have the port iBlankZ  input  1  leading-zero suppression enable.
REQ-007 The block SHALL have the port oAn  output  4  active-low one-hot digit select; oAn[0] selects digit 1, oAn[3] selects digit 4.
REQ-008 The block SHALL have the port oSeg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-009 The block SHALL have the port oFrame  output  1  registered one-cycle pulse, high in the cycle after each snapshot load.

Function
REQ-010 The block SHALL hold a prescaler pre (0..SCAN_DIV-1), a slot index idx (0..3), a 16-bit snapshot snap, and a load-pending flag pend.
REQ-011 While iEn=1, pre SHALL increment each cycle; at pre=SCAN_DIV-1, pre SHALL wrap to 0 and idx SHALL advance 0->1->2->3->0.
REQ-012 While iEn=0, pre, idx, snap and pend SHALL hold; oAn SHALL be 4'b1111 and oSeg SHALL be 7'b1111111.
REQ-013 snap SHALL load {iD4,iD3,iD2,iD1}, in the same clock edge, in both of the following cases:
- in an iEn=1 cycle with pend=1 (pend then clears);
- in an iEn=1 cycle with idx=3 and pre=SCAN_DIV-1 (frame end).
REQ-014 Input changes between loads SHALL NOT affect the display, so every displayed frame is coherent.
REQ-015 When iEn=1, oAn SHALL drive low only bit idx; oAn and oSeg SHALL be decoded only from registered state (idx, snap, iBlankZ), with no path from iD1..iD4.
REQ-016 Hex decode (active-low {g..a}) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000;
- 4=0011001, 5=0010010, 6=0000010, 7=1111000;
- 8=0000000, 9=0010000, A=0001000, b=0000011;
- C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 With iBlankZ=1, digit k (k=2..4) SHALL show 1111111 when it and all more-significant snapshot digits are 0; digit 1 SHALL never be blanked.
REQ-018 oFrame SHALL pulse high for exactly one cycle after every snap load, including the first load after reset.
REQ-019 iBlankZ SHALL take effect in the same cycle it changes; it is not snapshotted.

Reset
REQ-020 iRst=1 at a rising edge SHALL set pre=0, idx=0, snap=0, pend=1 and oFrame=0.
REQ-021 While iRst=1, oAn SHALL be 4'b1111 and oSeg SHALL be 7'b1111111, regardless of iEn.
REQ-022 iRst SHALL take priority over iEn and over a snapshot load in the same cycle.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; the first iEn=1 cycle after release SHALL show slot 0 and load snap.

Verification
REQ-024 Reset: iRst=1 for 3 cycles, iEn=1 -> oAn=1111, oSeg=1111111, oFrame=0 throughout.
REQ-025 Scan: SCAN_DIV=4, iD4..iD1=4,3,2,1, iEn=1 -> after the first frame, oAn steps 1110,1101,1011,0111 for 4 cycles each; oSeg steps 1111001, 0100100, 0110000, 0011001; oFrame pulses every 16 cycles.
REQ-026 Coherence: change iD1 from 1 to 9 during slot 2 -> digit 1 keeps showing 1111001 until after the next oFrame pulse, then shows 0010000.
REQ-027 Zero blanking: iBlankZ=1 with the following digits ->
- iD4..iD1=0,0,0,5: digits 4..2 show 1111111, digit 1 shows 0010010;
- iD4..iD1=0,7,0,5: digit 2 shows 1000000;
- all digits 0: digit 1 shows 1000000.
REQ-028 Pause: drop iEn for 10 cycles at pre=1 of slot 2 -> outputs blank for those cycles; on resume, slot 2 shows for its remaining 3 cycles; no extra oFrame pulse.
REQ-029 Mid-frame reset: assert iRst in slot 3, release, iEn=1 -> oAn=1110 on the first enabled cycle and oFrame high on the next.

Source files
------------

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner.
// A prescaler paces a slot index across the four digits. The hex inputs are
// snapshotted only at frame boundaries, or on the first enabled cycle after
// reset, so every displayed frame is coherent. Leading zeros can be blanked.
// The anode and segment outputs are decoded from registered state only.
module seg7_scan #(
    parameter int SCAN_DIV = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic [3:0] iD1,
    input  logic [3:0] iD2,
    input  logic [3:0] iD3,
    input  logic [3:0] iD4,
    input  logic       iBlankZ,
    output logic [3:0] oAn,
    output logic [6:0] oSeg,
    output logic       oFrame
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] preReg;
    logic [PW-1:0] preNext;
    logic [1:0]    idxReg;
    logic [1:0]    idxNext;
    logic [15:0]   snapReg;
    logic          pendReg;
    logic          frameReg;

    logic          frameEnd;
    logic          loadSnap;

    logic [3:0]    digitVal [4];
    logic [3:0]    blankDigit;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hexToSeg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The load happens at the end of the last slot, or on the first
    // enabled cycle after reset (pending flag).
    assign frameEnd = (idxReg == 2'd3) && (preReg == PRE_LAST);
    assign loadSnap = iEn && (pendReg || frameEnd);

    // Prescaler and slot index advance only while enabled.
    always_comb begin
        preNext = preReg;
        idxNext = idxReg;
        if (iEn) begin
            if (preReg == PRE_LAST) begin
                preNext = '0;
                idxNext = idxReg + 2'd1;
            end else begin
                preNext = preReg + PW'(1);
            end
        end
    end

    // State register. Reset wins over enable and over a snapshot load.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            preReg   <= '0;
            idxReg   <= 2'd0;
            snapReg  <= 16'h0000;
            pendReg  <= 1'b1;
            frameReg <= 1'b0;
        end else begin
            preReg   <= preNext;
            idxReg   <= idxNext;
            frameReg <= loadSnap;
            if (loadSnap) begin
                snapReg <= {iD4, iD3, iD2, iD1};
                pendReg <= 1'b0;
            end
        end
    end

    // Split the snapshot into digits. A digit is a leading zero when it
    // and every more-significant digit are zero. Digit 1 is never blanked.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : gDigit
            assign digitVal[gi] = snapReg[gi*4 +: 4];
            if (gi == 0) begin : gFirst
                assign blankDigit[gi] = 1'b0;
            end else begin : gUpper
                assign blankDigit[gi] = iBlankZ && (snapReg[15:gi*4] == '0);
            end
        end
    endgenerate

    // Output decode. The display is dark during reset and while disabled.
    always_comb begin
        oAn  = 4'b1111;
        oSeg = 7'b1111111;
        if (!iRst && iEn) begin
            oAn          = 4'b1111;
            oAn[idxReg]  = 1'b0;
            oSeg         = blankDigit[idxReg] ? 7'b1111111 : hexToSeg(digitVal[idxReg]);
        end
    end

    assign oFrame = frameReg;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan. A literal vector table, several
// hand-written corner sequences and a random run, all checked against a
// count-based behavioural model of the scanner.
module tb_seg7_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       bz = 1'b0;
    logic [3:0] d1 = 4'h0;
    logic [3:0] d2 = 4'h0;
    logic [3:0] d3 = 4'h0;
    logic [3:0] d4 = 4'h0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;

    always #5 clk = ~clk;

    seg7_scan #(.SCAN_DIV(DIV)) dut (
        .iClk   (clk),
        .iRst   (rst),
        .iEn    (en),
        .iD1    (d1),
        .iD2    (d2),
        .iD3    (d3),
        .iD4    (d4),
        .iBlankZ(bz),
        .oAn    (an),
        .oSeg   (seg),
        .oFrame (frame)
    );

    int checks = 0;
    int errors = 0;

    // Reference data taken straight from the digit table.
    logic [6:0] segTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] anTab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Model: number of enabled cycles since reset fixes slot and prescaler.
    int         mCount = 0;
    logic [3:0] mSnap [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic       mFrame = 1'b0;
    logic       mValid = 1'b0;

    logic [3:0] lastAn;
    logic [6:0] lastSeg;
    logic       lastFrame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock transaction: drive, sample mid-cycle, compare, advance model.
    task automatic cycle(input logic r, input logic e, input logic [15:0] d, input logic b);
        int         slot;
        logic [3:0] expAn;
        logic [6:0] expSeg;
        logic       allZero;
        logic       load;
        @(negedge clk);
        rst = r;
        en  = e;
        {d4, d3, d2, d1} = d;
        bz  = b;
        #2;
        lastAn    = an;
        lastSeg   = seg;
        lastFrame = frame;
        expAn  = 4'b1111;
        expSeg = 7'b1111111;
        if (!r && e) begin
            slot  = (mCount / DIV) % 4;
            expAn = anTab[slot];
            allZero = 1'b1;
            for (int k = slot; k < 4; k++)
                if (mSnap[k] != 4'h0) allZero = 1'b0;
            if (!(b && slot != 0 && allZero)) expSeg = segTab[mSnap[slot]];
        end
        check("an", {28'b0, an}, {28'b0, expAn});
        check("seg", {25'b0, seg}, {25'b0, expSeg});
        if (mValid) check("frame", {31'b0, frame}, {31'b0, mFrame});
        $display("cyc rst=%0b en=%0b d=%h bz=%0b an=%b seg=%b frame=%0b",
                 r, e, d, b, an, seg, frame);
        @(posedge clk);
        if (r) begin
            mCount = 0;
            for (int k = 0; k < 4; k++) mSnap[k] = 4'h0;
            mFrame = 1'b0;
            mValid = 1'b1;
        end else if (e) begin
            load = (mCount == 0) || (mCount % (4*DIV) == 4*DIV - 1);
            if (load) for (int k = 0; k < 4; k++) mSnap[k] = d[k*4 +: 4];
            mFrame = load;
            mCount++;
        end else begin
            mFrame = 1'b0;
        end
    endtask

    // Capture the segment pattern of each slot for one set of digits.
    task automatic blankShot(input logic [15:0] d, input logic [27:0] exp);
        logic [6:0] cap [4];
        cycle(1'b1, 1'b1, d, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, d, 1'b1);
            if (i == 2)  cap[0] = lastSeg;
            if (i == 6)  cap[1] = lastSeg;
            if (i == 10) cap[2] = lastSeg;
            if (i == 14) cap[3] = lastSeg;
        end
        for (int k = 0; k < 4; k++)
            check("blank_digit", {25'b0, cap[k]}, {25'b0, exp[k*7 +: 7]});
    endtask

    typedef struct {
        logic        r;
        logic        e;
        logic [15:0] d;
        logic        b;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int pulses;
        logic r;
        logic e;
        logic b;
        logic [15:0] d;

        // Reset holds the display dark, then the first frame loads 4321.
        tbl[0] = '{1'b1, 1'b1, 16'h4321, 1'b0, 4'b1111, 7'b1111111, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 16'h4321, 1'b0, 4'b1111, 7'b1111111, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h4321, 1'b0, 4'b1111, 7'b1111111, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'h4321, 1'b0, 4'b1110, 7'b1000000, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h4321, 1'b0, 4'b1110, 7'b1111001, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 16'h4321, 1'b0, 4'b1110, 7'b1111001, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 16'h4321, 1'b0, 4'b1110, 7'b1111001, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 16'h4321, 1'b0, 4'b1101, 7'b0100100, 1'b0};
        tbl[8] = '{1'b0, 0, 16'h4321, 1'b0, 4'b1111, 7'b1111111, 1'b0};

        cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].b);
            check("tbl_an", {28'b0, lastAn}, {28'b0, tbl[i].an});
            check("tbl_seg", {25'b0, lastSeg}, {25'b0, tbl[i].seg});
            check("tbl_frame", {31'b0, lastFrame}, {31'b0, tbl[i].fr});
        end

        // Full scan: slot steps and frame pulses every 16 cycles.
        cycle(1'b1, 1'b1, 16'h4321, 1'b0);
        pulses = 0;
        for (int i = 0; i < 49; i++) begin
            cycle(1'b0, 1'b1, 16'h4321, 1'b0);
            if (lastFrame) pulses++;
            if (i >= 16 && i < 32) begin
                check("scan_an", {28'b0, lastAn}, {28'b0, anTab[(i / 4) % 4]});
                check("scan_seg", {25'b0, lastSeg}, {25'b0, segTab[(i / 4) % 4 + 1]});
            end
        end
        check("scan_pulses", pulses, 4);

        // Coherence: iD1 changes during slot 2, shows only after the next load.
        cycle(1'b1, 1'b1, 16'h4321, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 16'h4321, 1'b0);
            if (i == 2) check("coh_old", {25'b0, lastSeg}, {25'b0, 7'b1111001});
        end
        for (int i = 9; i < 20; i++) begin
            cycle(1'b0, 1'b1, 16'h4329, 1'b0);
            if (i == 16) begin
                check("coh_new", {25'b0, lastSeg}, {25'b0, 7'b0010000});
                check("coh_frame", {31'b0, lastFrame}, 32'd1);
            end
        end

        // Leading-zero blanking.
        blankShot(16'h0005, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010});
        blankShot(16'h0705, {7'b1111111, 7'b1111000, 7'b1000000, 7'b0010010});
        blankShot(16'h0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});

        // Pause at pre=1 of slot 2, then resume for the rest of the frame.
        cycle(1'b1, 1'b1, 16'h4321, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 16'h4321, 1'b0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 16'h4321, 1'b0);
            if (lastFrame) pulses++;
            check("pause_an", {28'b0, lastAn}, {28'b0, 4'b1111});
        end
        check("pause_pulses", pulses, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b1, 16'h4321, 1'b0);
            if (lastFrame) pulses++;
            if (i < 3) check("resume_an", {28'b0, lastAn}, {28'b0, 4'b1011});
            if (i == 3) check("resume_next", {28'b0, lastAn}, {28'b0, 4'b0111});
        end
        check("resume_pulses", pulses, 1);

        // Reset in slot 3 abandons the frame.
        cycle(1'b1, 1'b1, 16'h4321, 1'b0);
        for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1, 16'h4321, 1'b0);
        cycle(1'b1, 1'b1, 16'h4321, 1'b0);
        cycle(1'b1, 1'b1, 16'h4321, 1'b0);
        cycle(1'b0, 1'b1, 16'h4321, 1'b0);
        check("mid_rst_an", {28'b0, lastAn}, {28'b0, 4'b1110});
        cycle(1'b0, 1'b1, 16'h4321, 1'b0);
        check("mid_rst_frame", {31'b0, lastFrame}, 32'd1);

        // Random traffic against the model.
        d = 16'h1234;
        b = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d[15:8] = 8'h00;
            if ($urandom_range(0, 19) == 0) b = ~b;
            cycle(r, e, d, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
